// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - integer reservation station with dual-CDB wakeup and single registered dispatch
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic [5:0]       issue_op,
  input  logic [31:0]      issue_vj,
  input  logic             issue_qj_busy,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qk_busy,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic [31:0]      issue_imm,
  input  logic [ROB_W-1:0] issue_robid,
  input  logic [31:0]      issue_pc,
  output logic             rs_full,
  input  logic             alu_cdb_enable,
  input  logic [ROB_W-1:0] alu_cdb_robid,
  input  logic [31:0]      alu_cdb_value,
  input  logic             lsb_cdb_enable,
  input  logic [ROB_W-1:0] lsb_cdb_robid,
  input  logic [31:0]      lsb_cdb_value,
  output logic             alu_valid,
  output logic [5:0]       alu_op,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_vk,
  output logic [31:0]      alu_imm,
  output logic [ROB_W-1:0] alu_robid,
  output logic [31:0]      alu_pc
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy;
  logic [5:0]         e_op    [RS_SIZE];
  logic [31:0]        e_vj    [RS_SIZE];
  logic [31:0]        e_vk    [RS_SIZE];
  logic [31:0]        e_imm   [RS_SIZE];
  logic [31:0]        e_pc    [RS_SIZE];
  logic [ROB_W-1:0]   e_qj    [RS_SIZE];
  logic [ROB_W-1:0]   e_qk    [RS_SIZE];
  logic [ROB_W-1:0]   e_robid [RS_SIZE];
  logic               e_qj_busy [RS_SIZE];
  logic               e_qk_busy [RS_SIZE];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             ready_found;
  logic [IDX_W-1:0] ready_idx;
  logic [31:0]      fwd_vj;
  logic [31:0]      fwd_vk;
  logic             fwd_qj_busy;
  logic             fwd_qk_busy;

  assign rs_full = &busy;

  // Lowest-index free slot for issue and lowest-index ready slot for dispatch
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && !e_qj_busy[i] && !e_qk_busy[i]) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
    end
  end

  // Same-cycle CDB forwarding onto the issuing operands, ALU bus checked first
  always_comb begin
    fwd_vj      = issue_vj;
    fwd_qj_busy = issue_qj_busy;
    fwd_vk      = issue_vk;
    fwd_qk_busy = issue_qk_busy;
    if (issue_qj_busy) begin
      if (alu_cdb_enable && alu_cdb_robid == issue_qj) begin
        fwd_vj      = alu_cdb_value;
        fwd_qj_busy = 1'b0;
      end else if (lsb_cdb_enable && lsb_cdb_robid == issue_qj) begin
        fwd_vj      = lsb_cdb_value;
        fwd_qj_busy = 1'b0;
      end
    end
    if (issue_qk_busy) begin
      if (alu_cdb_enable && alu_cdb_robid == issue_qk) begin
        fwd_vk      = alu_cdb_value;
        fwd_qk_busy = 1'b0;
      end else if (lsb_cdb_enable && lsb_cdb_robid == issue_qk) begin
        fwd_vk      = lsb_cdb_value;
        fwd_qk_busy = 1'b0;
      end
    end
  end

  // Entry table update: dispatch, CDB wakeup and issue all in one edge
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy      <= '0;
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_vj    <= '0;
      alu_vk    <= '0;
      alu_imm   <= '0;
      alu_robid <= '0;
      alu_pc    <= '0;
    end else if (rdy) begin
      if (ready_found) begin
        alu_valid <= 1'b1;
        alu_op    <= e_op[ready_idx];
        alu_vj    <= e_vj[ready_idx];
        alu_vk    <= e_vk[ready_idx];
        alu_imm   <= e_imm[ready_idx];
        alu_robid <= e_robid[ready_idx];
        alu_pc    <= e_pc[ready_idx];
      end else begin
        alu_valid <= 1'b0;
        alu_op    <= '0;
      end

      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && e_qj_busy[i]) begin
          if (alu_cdb_enable && alu_cdb_robid == e_qj[i]) begin
            e_vj[i]      <= alu_cdb_value;
            e_qj_busy[i] <= 1'b0;
          end else if (lsb_cdb_enable && lsb_cdb_robid == e_qj[i]) begin
            e_vj[i]      <= lsb_cdb_value;
            e_qj_busy[i] <= 1'b0;
          end
        end
        if (busy[i] && e_qk_busy[i]) begin
          if (alu_cdb_enable && alu_cdb_robid == e_qk[i]) begin
            e_vk[i]      <= alu_cdb_value;
            e_qk_busy[i] <= 1'b0;
          end else if (lsb_cdb_enable && lsb_cdb_robid == e_qk[i]) begin
            e_vk[i]      <= lsb_cdb_value;
            e_qk_busy[i] <= 1'b0;
          end
        end
      end

      // The dispatched slot is busy and the issue slot is free, so they never coincide
      if (ready_found) begin
        busy[ready_idx] <= 1'b0;
      end

      if (issue_valid && !rs_full && free_found) begin
        busy[free_idx]      <= 1'b1;
        e_op[free_idx]      <= issue_op;
        e_vj[free_idx]      <= fwd_vj;
        e_vk[free_idx]      <= fwd_vk;
        e_qj_busy[free_idx] <= fwd_qj_busy;
        e_qk_busy[free_idx] <= fwd_qk_busy;
        e_qj[free_idx]      <= issue_qj;
        e_qk[free_idx]      <= issue_qk;
        e_imm[free_idx]     <= issue_imm;
        e_robid[free_idx]   <= issue_robid;
        e_pc[free_idx]      <= issue_pc;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed and randomized check of reservation_station against a slot-table model
module tb_reservation_station;

  localparam int N = 16;
  localparam int W = 4;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_ADDI = 6'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy, flush;
  logic          issue_valid;
  logic [5:0]    issue_op;
  logic [31:0]   issue_vj, issue_vk, issue_imm, issue_pc;
  logic          issue_qj_busy, issue_qk_busy;
  logic [W-1:0]  issue_qj, issue_qk, issue_robid;
  logic          rs_full;
  logic          alu_cdb_enable, lsb_cdb_enable;
  logic [W-1:0]  alu_cdb_robid, lsb_cdb_robid;
  logic [31:0]   alu_cdb_value, lsb_cdb_value;
  logic          alu_valid;
  logic [5:0]    alu_op;
  logic [31:0]   alu_vj, alu_vk, alu_imm, alu_pc;
  logic [W-1:0]  alu_robid;

  reservation_station #(.RS_SIZE(N), .ROB_W(W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
    .issue_vk(issue_vk), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
    .issue_imm(issue_imm), .issue_robid(issue_robid), .issue_pc(issue_pc),
    .rs_full(rs_full),
    .alu_cdb_enable(alu_cdb_enable), .alu_cdb_robid(alu_cdb_robid), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_enable(lsb_cdb_enable), .lsb_cdb_robid(lsb_cdb_robid), .lsb_cdb_value(lsb_cdb_value),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_vj(alu_vj), .alu_vk(alu_vk),
    .alu_imm(alu_imm), .alu_robid(alu_robid), .alu_pc(alu_pc)
  );

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a table of waiting instructions plus the last dispatched record
  logic         mb   [N];
  logic [5:0]   mop  [N];
  logic [31:0]  mvj  [N], mvk [N], mimm [N], mpc [N];
  logic [W-1:0] mqj  [N], mqk [N], mrob [N];
  logic         mqjb [N], mqkb [N];
  logic         x_valid;
  logic [5:0]   x_op;
  logic [31:0]  x_vj, x_vk, x_imm, x_pc;
  logic [W-1:0] x_rob;

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!mb[i]) return 1'b0;
    return 1'b1;
  endfunction

  // {still_waiting, value} for an operand after looking at this cycle's buses
  function automatic logic [32:0] resolve(logic waiting, logic [W-1:0] tag, logic [31:0] v);
    if (!waiting) return {1'b0, v};
    if (alu_cdb_enable && alu_cdb_robid == tag) return {1'b0, alu_cdb_value};
    if (lsb_cdb_enable && lsb_cdb_robid == tag) return {1'b0, lsb_cdb_value};
    return {1'b1, v};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mb[i] = 1'b0;
    x_valid = 0; x_op = 0; x_vj = 0; x_vk = 0; x_imm = 0; x_pc = 0; x_rob = 0;
  endtask

  task automatic model_step();
    int d;
    int f;
    bit full;
    logic [32:0] r;
    d = -1;
    f = -1;
    if (rst || flush) begin
      model_clear();
    end else if (rdy) begin
      full = m_full();
      for (int i = 0; i < N; i++) begin
        if (d < 0 && mb[i] && !mqjb[i] && !mqkb[i]) d = i;
        if (f < 0 && !mb[i]) f = i;
      end
      if (d >= 0) begin
        x_valid = 1; x_op = mop[d]; x_vj = mvj[d]; x_vk = mvk[d];
        x_imm = mimm[d]; x_pc = mpc[d]; x_rob = mrob[d];
      end else begin
        x_valid = 0; x_op = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (mb[i]) begin
          r = resolve(mqjb[i], mqj[i], mvj[i]); mqjb[i] = r[32]; mvj[i] = r[31:0];
          r = resolve(mqkb[i], mqk[i], mvk[i]); mqkb[i] = r[32]; mvk[i] = r[31:0];
        end
      end
      if (d >= 0) mb[d] = 1'b0;
      if (issue_valid && !full && f >= 0) begin
        mb[f] = 1'b1; mop[f] = issue_op; mimm[f] = issue_imm; mpc[f] = issue_pc;
        mrob[f] = issue_robid; mqj[f] = issue_qj; mqk[f] = issue_qk;
        r = resolve(issue_qj_busy, issue_qj, issue_vj); mqjb[f] = r[32]; mvj[f] = r[31:0];
        r = resolve(issue_qk_busy, issue_qk, issue_vk); mqkb[f] = r[32]; mvk[f] = r[31:0];
      end
    end
  endtask

  // Every cycle after the first reset the outputs must match the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_valid", {31'd0, alu_valid}, {31'd0, x_valid});
      chk("model_op", {26'd0, alu_op}, {26'd0, x_op});
      chk("model_vj", alu_vj, x_vj);
      chk("model_vk", alu_vk, x_vk);
      chk("model_imm", alu_imm, x_imm);
      chk("model_pc", alu_pc, x_pc);
      chk("model_robid", {28'd0, alu_robid}, {28'd0, x_rob});
      chk("model_full", {31'd0, rs_full}, {31'd0, m_full()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    rst = 0; flush = 0; rdy = 1;
    issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0; issue_imm = 0; issue_pc = 0;
    issue_qj_busy = 0; issue_qk_busy = 0; issue_qj = 0; issue_qk = 0; issue_robid = 0;
    alu_cdb_enable = 0; alu_cdb_robid = 0; alu_cdb_value = 0;
    lsb_cdb_enable = 0; lsb_cdb_robid = 0; lsb_cdb_value = 0;
  endtask

  task automatic issue_set(logic [5:0] op, logic [31:0] vj, logic qjb, logic [W-1:0] qj,
                           logic [31:0] vk, logic qkb, logic [W-1:0] qk,
                           logic [31:0] imm, logic [W-1:0] rob, logic [31:0] pc);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_qj_busy = qjb; issue_qj = qj;
    issue_vk = vk; issue_qk_busy = qkb; issue_qk = qk; issue_imm = imm;
    issue_robid = rob; issue_pc = pc;
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    cmp_en = 1'b1;
    idle();
    chk("reset_valid", {31'd0, alu_valid}, 32'd0);
    chk("reset_full", {31'd0, rs_full}, 32'd0);
    chk("reset_robid", {28'd0, alu_robid}, 32'd0);

    // 1: ready ADD dispatches one cycle after issue
    issue_set(OP_ADD, 5, 0, 0, 7, 0, 0, 0, 3, 32'h100);
    step(); idle();
    chk("t1_not_yet", {31'd0, alu_valid}, 32'd0);
    step();
    chk("t1_valid", {31'd0, alu_valid}, 32'd1);
    chk("t1_vj", alu_vj, 32'd5);
    chk("t1_vk", alu_vk, 32'd7);
    chk("t1_robid", {28'd0, alu_robid}, 32'd3);
    chk("t1_op", {26'd0, alu_op}, {26'd0, OP_ADD});
    step();
    chk("t1_drop", {31'd0, alu_valid}, 32'd0);

    // 2: wait on tag 2, wake from ALU CDB after 3 idle cycles
    issue_set(OP_ADDI, 0, 1, 2, 0, 0, 0, 10, 4, 32'h104);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_waiting", {31'd0, alu_valid}, 32'd0);
    end
    alu_cdb_enable = 1; alu_cdb_robid = 2; alu_cdb_value = 32'h20;
    step(); idle();
    chk("t2_bcast_edge", {31'd0, alu_valid}, 32'd0);
    step();
    chk("t2_valid", {31'd0, alu_valid}, 32'd1);
    chk("t2_vj", alu_vj, 32'h20);
    chk("t2_imm", alu_imm, 32'd10);
    step();

    // 3: LSB CDB forwarded into the issuing operand
    issue_set(OP_ADD, 1, 0, 0, 0, 1, 6, 0, 5, 32'h108);
    lsb_cdb_enable = 1; lsb_cdb_robid = 6; lsb_cdb_value = 32'hDEAD;
    step(); idle();
    step();
    chk("t3_valid", {31'd0, alu_valid}, 32'd1);
    chk("t3_vk", alu_vk, 32'hDEAD);
    step();

    // 4: fill all slots on tag 9, overflow issue ignored, drain in index order
    for (int i = 0; i < N; i++) begin
      issue_set(OP_ADD, 0, 1, 9, 1, 0, 0, 0, W'(i), 32'h1000 + 32'(4 * i));
      step();
      if (i == N - 2) chk("t4_not_full", {31'd0, rs_full}, 32'd0);
    end
    chk("t4_full", {31'd0, rs_full}, 32'd1);
    issue_set(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 4'd15, 32'hBAD0);
    step(); idle();
    chk("t4_still_full", {31'd0, rs_full}, 32'd1);
    chk("t4_no_overflow_disp", {31'd0, alu_valid}, 32'd0);
    alu_cdb_enable = 1; alu_cdb_robid = 9; alu_cdb_value = 32'h900;
    step(); idle();
    for (int k = 0; k < N; k++) begin
      step();
      chk("t4_valid", {31'd0, alu_valid}, 32'd1);
      chk("t4_order_pc", alu_pc, 32'h1000 + 32'(4 * k));
      chk("t4_vj", alu_vj, 32'h900);
      if (k == 0) chk("t4_full_falls", {31'd0, rs_full}, 32'd0);
    end
    step();
    chk("t4_drained", {31'd0, alu_valid}, 32'd0);

    // 5: flush with waiting entries and a ready one about to dispatch
    for (int i = 0; i < 5; i++) begin
      issue_set(OP_ADD, 0, 1, 4, 0, 0, 0, 0, W'(i), 32'h2000);
      step();
    end
    issue_set(OP_ADD, 3, 0, 0, 3, 0, 0, 0, 5, 32'h2004);
    step(); idle();
    flush = 1;
    step(); idle();
    chk("t5_valid", {31'd0, alu_valid}, 32'd0);
    chk("t5_full", {31'd0, rs_full}, 32'd0);
    chk("t5_pc", alu_pc, 32'd0);
    alu_cdb_enable = 1; alu_cdb_robid = 4; alu_cdb_value = 32'h44;
    step(); idle();
    step();
    chk("t5_no_ghost", {31'd0, alu_valid}, 32'd0);
    step();
    chk("t5_no_ghost2", {31'd0, alu_valid}, 32'd0);

    // 6: rdy low freezes dispatch and drops the broadcast
    issue_set(OP_ADD, 0, 1, 11, 0, 0, 0, 0, 1, 32'h3000);
    step();
    issue_set(OP_ADD, 32'h111, 0, 0, 0, 0, 0, 0, 2, 32'h3004);
    step(); idle();
    rdy = 0; alu_cdb_enable = 1; alu_cdb_robid = 11; alu_cdb_value = 32'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_frozen_valid", {31'd0, alu_valid}, 32'd0);
      chk("t6_frozen_pc", alu_pc, 32'd0);
    end
    idle();
    step();
    chk("t6_valid", {31'd0, alu_valid}, 32'd1);
    chk("t6_vj", alu_vj, 32'h111);
    chk("t6_robid", {28'd0, alu_robid}, 32'd2);
    step();
    chk("t6_not_captured", {31'd0, alu_valid}, 32'd0);
    alu_cdb_enable = 1; alu_cdb_robid = 11; alu_cdb_value = 32'h99;
    step(); idle();
    step();
    chk("t6_late_valid", {31'd0, alu_valid}, 32'd1);
    chk("t6_late_vj", alu_vj, 32'h99);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      idle();
      rst   = ($urandom_range(0, 799) == 0);
      flush = ($urandom_range(0, 59) == 0);
      rdy   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0 && (!rs_full || $urandom_range(0, 3) == 0)) begin
        issue_set(6'($urandom_range(1, 63)), $urandom, $urandom_range(0, 1) == 1, W'($urandom_range(0, 7)),
                  $urandom, $urandom_range(0, 1) == 1, W'($urandom_range(0, 7)),
                  $urandom, W'($urandom_range(0, 15)), $urandom);
      end
      alu_cdb_enable = ($urandom_range(0, 1) == 1);
      alu_cdb_robid  = W'($urandom_range(0, 7));
      alu_cdb_value  = $urandom;
      lsb_cdb_enable = ($urandom_range(0, 2) == 0);
      lsb_cdb_robid  = W'((32'(alu_cdb_robid) + 32'($urandom_range(1, 7))) % 8);
      lsb_cdb_value  = $urandom;
      step();
    end
    idle();
    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Integer reservation station sitting between the issue/decode stage and the combinational ALU.
- Buffers issued ALU/branch/jump ops until both source operands are available, snooping two common data buses (ALU CDB and load/store CDB).
- Each cycle it dispatches at most one ready entry through registered outputs that drive the ALU directly.
- Cleared wholesale by ROB rollback (flush).

Parameters:
- RS_SIZE, 16, number of entries (power of two, >=2).
- ROB_W, 4, width of ROB tags; equals ROB_SIZE_LOG.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; low = freeze.
- flush  in  1  ROB rollback; discard all entries.
- issue_valid  in  1  new instruction this cycle.
- issue_op  in  6  opcode; OP_NULL = 0.
- issue_vj  in  32  rs1 value when not pending.
- issue_qj_busy  in  1  rs1 waits on a ROB tag.
- issue_qj  in  ROB_W  rs1 producer tag.
- issue_vk  in  32  rs2 value.
- issue_qk_busy  in  1  rs2 waits on a ROB tag.
- issue_qk  in  ROB_W  rs2 producer tag.
- issue_imm  in  32  immediate.
- issue_robid  in  ROB_W  destination ROB tag.
- issue_pc  in  32  instruction pc.
- rs_full  out  1  no free entry.
- alu_cdb_enable  in  1  ALU broadcast valid.
- alu_cdb_robid  in  ROB_W  ALU broadcast tag.
- alu_cdb_value  in  32  ALU broadcast value.
- lsb_cdb_enable  in  1  LSB broadcast valid.
- lsb_cdb_robid  in  ROB_W  LSB broadcast tag.
- lsb_cdb_value  in  32  LSB broadcast value.
- alu_valid  out  1  dispatch valid (to ALU RS_valid).
- alu_op  out  6  to RS_op.
- alu_vj  out  32  to RS_vj.
- alu_vk  out  32  to RS_vk.
- alu_imm  out  32  to RS_imm.
- alu_robid  out  ROB_W  to RS_ROBid.
- alu_pc  out  32  to RS_curpc.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All state changes on posedge clk.
- Priority per edge: rst > flush > !rdy (hold everything, outputs unchanged) > normal operation.
- Reset and flush values:
  - All entries freed.
  - alu_valid=0, alu_op=0, alu_vj/vk/imm/pc=0, alu_robid=0.
  - rs_full=0 after either.
  - Flush in the same cycle as issue or dispatch: the issue is dropped and alu_valid=0.
- Entry state: busy, op, vj, vk, qj, qk, qj_busy, qk_busy, imm, robid, pc.
- rs_full:
  - Combinational; equals "all RS_SIZE entries busy" from registered state.
  - No bypass from a same-cycle dispatch.
  - issue_valid while rs_full=1 is a protocol violation; the RS ignores it.
- Issue:
  - On issue_valid, the lowest-index free entry is written.
  - Same-cycle forwarding: if issue_qj_busy and a CDB enable with robid==issue_qj is present this cycle, store that value with qj_busy=0. Same rule for qk. ALU CDB is checked before LSB CDB (tags never collide).
- Wakeup: at each edge, every busy entry with qj_busy=1 and a matching enabled CDB tag captures the value and clears qj_busy. Same for qk. Both operands may wake in one cycle.
- Ready: busy && !qj_busy && !qk_busy.
- Dispatch:
  - Lowest-index ready entry, evaluated on registered state.
  - At the edge, its fields load into the alu_* registers, alu_valid=1, and the entry is freed.
  - With no ready entry: alu_valid=0, alu_op=0; other alu_* hold.
  - An entry that becomes ready or is written at edge E dispatches at edge E+1 at the earliest. Issue-to-ALU latency is therefore 1 cycle with operands ready, or 1 cycle after the waking broadcast.
- Simultaneous events: issue, wakeup, and dispatch of different entries in one cycle are all honoured. A freed slot is reusable from the next cycle.
- Throughput: one dispatch per cycle sustained.

Test Plan:
1. Reset, then issue ADD (op code of OP_ADD) vj=5, vk=7, robid=3, no deps -> next cycle alu_valid=1, alu_vj=5, alu_vk=7, alu_robid=3; the cycle after, alu_valid=0.
2. Issue ADDI qj_busy=1, qj=2, imm=10; hold 3 cycles, then alu_cdb_enable=1, robid=2, value=0x20 -> alu_valid=1 exactly one cycle after the broadcast, alu_vj=0x20, alu_imm=10.
3. Same-cycle forwarding: issue with qk_busy=1, qk=6 while lsb_cdb_enable=1, robid=6, value=0xDEAD -> dispatched next cycle with alu_vk=0xDEAD.
4. Fill: issue 16 ops all dependent on tag 9 -> rs_full=1 after the 16th; a 17th issue is ignored. Broadcast tag 9 -> 16 consecutive dispatches in index order, rs_full falls after the first.
5. Flush with 5 busy entries and a pending ready entry -> next cycle alu_valid=0, rs_full=0. A later broadcast of the old tags produces no dispatch.
6. rdy=0 for 3 cycles with a ready entry and a CDB broadcast -> no state or output change. After rdy=1 the entry dispatches and the dropped broadcast is not captured.
